// File: rtl/mul_div_unit.sv
// Iterative 32-cycle multiply/divide unit with a start/busy/done handshake.
// Multiply is shift-add (LSB first) over a 64-bit accumulator; divide is
// restoring (MSB first). Signed operation works on magnitudes and fixes the
// result signs in a final cycle.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  aluop,
  input  logic        sign,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned ITERS = 32;
  localparam int unsigned CNT_W = 6;
  localparam logic [3:0]  OP_MULU = 4'b0011;
  localparam logic [3:0]  OP_DIVU = 4'b0100;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             div0;
  // multiplicand for multiply, divisor for divide
  logic [31:0]      opnd;
  // multiply: {partial product, remaining multiplier bits}
  // divide:   [31:0] holds dividend bits shifting out / quotient shifting in
  logic [63:0]      acc;
  logic [31:0]      rem;

  logic             op_legal;
  logic             op_div;
  logic [31:0]      mag_a;
  logic [31:0]      mag_b;
  logic [32:0]      mul_sum;
  logic [32:0]      div_trial;
  logic             div_ge;
  logic [31:0]      div_diff;
  logic [63:0]      prod_fix;
  logic [31:0]      quo_fix;
  logic [31:0]      rem_fix;

  // Operand decode, one iteration step of each algorithm, and sign fix-up
  always_comb begin
    op_legal  = (aluop == OP_MULU) || (aluop == OP_DIVU);
    op_div    = (aluop == OP_DIVU);
    mag_a     = (sign && a[31]) ? (~a + 32'd1) : a;
    mag_b     = (sign && b[31]) ? (~b + 32'd1) : b;

    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);

    // 33-bit partial remainder: previous remainder shifted with next dividend bit
    div_trial = {rem, acc[31]};
    div_ge    = (div_trial >= {1'b0, opnd});
    // Only taken when div_ge, so the difference is below the divisor and fits 32 bits
    div_diff  = div_trial[31:0] - opnd;

    prod_fix  = neg_q ? (~acc + 64'd1) : acc;
    // Divide-by-zero keeps the all-ones quotient; the remainder fix restores raw a
    quo_fix   = (neg_q && !div0) ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem_fix   = neg_r ? (~rem + 32'd1) : rem;
  end

  // Control FSM with registered outputs and iterative datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      rem    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (op_legal) begin
              state  <= CALC;
              cnt    <= '0;
              is_div <= op_div;
              neg_q  <= sign & (a[31] ^ b[31]);
              neg_r  <= sign & a[31];
              div0   <= (b == 32'd0);
              opnd   <= op_div ? mag_b : mag_a;
              acc    <= {32'd0, (op_div ? mag_a : mag_b)};
              rem    <= '0;
            end else begin
              state <= ERR;
            end
          end
        end

        CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (is_div) begin
            acc[31:0] <= {acc[30:0], div_ge};
            rem       <= div_ge ? div_diff : div_trial[31:0];
          end else begin
            acc <= {mul_sum, acc[31:1]};
          end
          if (cnt == LAST_ITER) begin
            state <= FIX;
          end
        end

        FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
          done  <= 1'b1;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        ERR: begin
          done  <= 1'b1;
          err   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table plus handshake,
// illegal-op and reset corner sequences, with a done-driven scoreboard.
module tb_mul_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  aluop;
  logic        sign;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] hi;
  logic [31:0] lo;

  localparam logic [3:0] MUL = 4'b0011;
  localparam logic [3:0] DIV = 4'b0100;
  localparam int NVEC = 18;

  typedef struct {
    logic [3:0]  op;
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  exp_t        sbq[$];
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;
  vec_t        vt[NVEC];

  mul_div_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .aluop (aluop),
    .sign  (sign),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: native 64-bit arithmetic, with the unit's divide-by-zero rule
  function automatic logic [63:0] model(input logic [3:0] op, input logic sg,
                                        input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p, q, r;
    sx = sg ? longint'($signed(x)) : longint'({32'd0, x});
    sy = sg ? longint'($signed(y)) : longint'({32'd0, y});
    if (op == MUL) begin
      p = sx * sy;
      return 64'(p);
    end
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  // Scoreboard: every done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      check("done_busy_overlap", 64'(busy), 64'd0);
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got a done pulse, expected none pending");
      end else begin
        e = sbq.pop_front();
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
        check("err", 64'(err), 64'(e.err));
      end
    end
  end

  // Drive a request for one edge and queue its expected result
  task automatic issue(input logic [3:0] op, input logic sg, input logic [31:0] aa,
                       input logic [31:0] bb, input logic [31:0] ehi, input logic [31:0] elo,
                       input logic eerr);
    exp_t e;
    e.hi  = ehi;
    e.lo  = elo;
    e.err = eerr;
    sbq.push_back(e);
    if (!eerr) begin
      mhi = ehi;
      mlo = elo;
    end
    start = 1'b1;
    aluop = op;
    sign  = sg;
    a     = aa;
    b     = bb;
    @(posedge clk);
    #1;
    start = 1'b0;
    aluop = 4'($urandom_range(0, 15));
    sign  = 1'($urandom_range(0, 1));
    a     = $urandom;
    b     = $urandom;
    check("busy_after_accept", 64'(busy), 64'd1);
  endtask

  // Count edges until done, checking latency and busy duration
  task automatic wait_done(input string name, input int exp_lat);
    int n = 0;
    int busy_cnt = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (busy) busy_cnt++;
    end
    check({name, "_latency"}, 64'(n), 64'(exp_lat));
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
  endtask

  initial begin
    logic [3:0]  rop;
    logic        rsg;
    logic [31:0] ra, rb;
    logic [63:0] r;
    int          ndone;

    start = 1'b0;
    aluop = 4'd0;
    sign  = 1'b0;
    a     = '0;
    b     = '0;
    rst_n = 1'b0;

    vt[0]  = '{MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vt[1]  = '{MUL, 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vt[2]  = '{DIV, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vt[3]  = '{DIV, 1'b0, 32'd100,       32'd7,         32'd2,         32'd14};
    vt[4]  = '{DIV, 1'b0, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    vt[5]  = '{DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vt[6]  = '{DIV, 1'b1, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vt[7]  = '{DIV, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vt[8]  = '{MUL, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vt[9]  = '{MUL, 1'b0, 32'h1234_5678, 32'd0,         32'd0,         32'd0};
    vt[10] = '{DIV, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF};
    vt[11] = '{MUL, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0};
    for (int i = 12; i < NVEC; i++) begin
      rop = (i % 2 == 0) ? MUL : DIV;
      rsg = 1'($urandom_range(0, 1));
      ra  = $urandom;
      rb  = (rop == DIV && i % 4 == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
      r   = model(rop, rsg, ra, rb);
      vt[i] = '{rop, rsg, ra, rb, r[63:32], r[31:0]};
    end

    // Asynchronous reset values, before any clock edge
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: each request issued during the previous done cycle
    for (int i = 0; i < NVEC; i++) begin
      issue(vt[i].op, vt[i].sg, vt[i].a, vt[i].b, vt[i].ehi, vt[i].elo, 1'b0);
      wait_done($sformatf("vec%0d", i), 33);
    end

    // Illegal op: one-cycle turnaround, hi/lo kept, err held until next done
    repeat (2) @(posedge clk);
    #1;
    issue(4'b0101, 1'b0, 32'd11, 32'd22, mhi, mlo, 1'b1);
    wait_done("illegal", 1);
    repeat (3) @(posedge clk);
    #1;
    check("err_held", 64'(err), 64'd1);
    check("hi_kept", 64'(hi), 64'(mhi));
    issue(MUL, 1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
    wait_done("after_illegal", 33);
    check("err_cleared", 64'(err), 64'd0);

    // Start pulsed while busy must be ignored
    repeat (2) @(posedge clk);
    #1;
    issue(DIV, 1'b0, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    aluop = MUL;
    sign  = 1'b0;
    a     = 32'd9;
    b     = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("start_while_busy", 28);
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("no_extra_done", 64'(ndone), 64'd0);

    // Explicit back-to-back: start raised during the done cycle
    issue(MUL, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0);
    wait_done("b2b_first", 33);
    check("done_at_second_start", 64'(done), 64'd1);
    issue(DIV, 1'b0, 32'd77, 32'd10, 32'd7, 32'd7, 1'b0);
    wait_done("b2b_second", 33);

    // Reset mid-operation: immediate clear, no stale done afterwards
    repeat (2) @(posedge clk);
    #1;
    issue(MUL, 1'b0, 32'd123, 32'd456, 32'd0, 32'd56088, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    sbq.delete();
    mhi = '0;
    mlo = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("no_done_after_reset", 64'(ndone), 64'd0);
    issue(DIV, 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);
    wait_done("after_reset", 33);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
